sn74163h: RTL and testbench
===========================

Name: sn74163h

Overview:
- Behavioural model of a 16-pin synchronous 4-bit binary counter (74163 pinout) with synchronous, active-high clear.
- Sits directly upstream of the quad-OR IC model: QA..QD drive the OR gate inputs on board-level benches, stepping through every input combination.
- Modelled at pin level; all ports use the DIP pin numbers.
- Supply pins gate all state changes.

Parameters:
- COUNT_MAX, 15, terminal count value (range 1..15). Output RCO is asserted at this value, and the count wraps to 0 after it. Set 9 for a decade variant.

Ports:
- P2 input 1 CLK: rising-edge clock.
- P1 input 1 RST: synchronous clear, active-high.
- P3 input 1 A: load data bit 0.
- P4 input 1 B: load data bit 1.
- P5 input 1 C: load data bit 2.
- P6 input 1 D: load data bit 3.
- P7 input 1 ENP: count enable (parallel).
- P8 input 1 GND: must be 0 for the device to operate.
- P9 input 1 LOAD_N: synchronous parallel load, active-low.
- P10 input 1 ENT: count enable (trickle); also gates RCO.
- P11 output 1 QD: count bit 3.
- P12 output 1 QC: count bit 2.
- P13 output 1 QB: count bit 1.
- P14 output 1 QA: count bit 0.
- P15 output 1 RCO: ripple carry out.
- P16 input 1 VCC: must be 1 for the device to operate.

Behaviour:
- Interface: one clock (P2); reset (P1) is synchronous and active-high.
- Powered means P16==1 and P8==0.
- Internal 4-bit state Q = {QD,QC,QB,QA}.
- State is updated only on a rising edge of P2 while powered.
- Unpowered edges are ignored, and Q holds its last value.
- Priority on each powered rising edge, highest first:
  1. P1==1: Q <= 0, regardless of LOAD_N, ENP or ENT.
  2. P9==0: Q <= {D,C,B,A}, regardless of ENP and ENT.
  3. P7==1 and P10==1: Q <= next(Q).
  4. Otherwise hold.
- next(Q) = 0 if Q >= COUNT_MAX, else Q+1 (4-bit arithmetic).
- A loaded value above COUNT_MAX returns to 0 on the next count edge.
- Reset value: QA=QB=QC=QD=0 on the first clock after P1 is sampled high.
- Before the first clear or load, Q is X. The model must not invent an initial value.
- Latency: Q changes in the same timestep as the clock edge (zero delay). Inputs are sampled on the edge.
- RCO is combinational: RCO = P10 & (Q==COUNT_MAX) & powered.
  - RCO is 0 while unpowered.
  - RCO is 0 after reset.
  - RCO follows ENT with no clock.
- Cascading: RCO of stage n feeds ENT of stage n+1, and ENP is common. Stage n+1 increments on the same edge on which stage n wraps to 0.
- Clear mid-count: takes effect on the next edge only. An asynchronous pulse of P1 between edges has no effect.
- Load and count requested together: load wins.
- Clear and load requested together: clear wins.
- Power drop mid-operation: Q freezes. When power returns, counting resumes from the frozen value, with no implicit reset.
- A change of P1, P7 or P9 without a rising P2 edge never alters Q.
- X/Z on P1 or P9 at a powered edge: Q <= X, so bench faults are exposed.

Test Plan:
- Reset: power on, P1=1 for one edge, then P1=0, P9=1, P7=P10=1 for 20 edges.
  - Required Q sequence: 0,1,2..15,0,1,2,3.
  - RCO=1 only while Q=15.
- Load priority:
  - Q=5, set P9=0 with D..A=1010 and P7=P10=1, one edge -> Q=10.
  - Same edge with P1=1 -> Q=0.
- Enables:
  - Q=3, P7=0, P10=1, 3 edges -> Q stays 3.
  - Then P7=1, P10=0 -> Q stays 3.
  - With Q=15 and P10 toggled 0/1 without a clock -> RCO follows P10 immediately.
- Power gating:
  - Q=7, P16=0, 4 edges -> Q=7 and RCO=0.
  - P16=1, 1 edge -> Q=8.
  - P8=1 behaves like P16=0.
- Decade/out-of-range (COUNT_MAX=9):
  - Count 0..9 then wraps to 0, and RCO=1 at 9.
  - Load 12, one count edge -> Q=0.
- Cascade: two instances with RCO0 to ENT1, both cleared, 40 edges.
  - Stage 1 increments exactly on edges 16 and 32.
  - Combined value = edge count mod 256.

Source files
------------

// File: rtl/sn74163h.sv
// Pin-level model of a 74163 synchronous 4-bit binary counter with
// synchronous clear, synchronous parallel load and supply-gated state.
module sn74163h #(
  parameter logic [3:0] COUNT_MAX = 4'd15
) (
  input  logic P1,   // RST, synchronous clear, active-high
  input  logic P2,   // CLK
  input  logic P3,   // A
  input  logic P4,   // B
  input  logic P5,   // C
  input  logic P6,   // D
  input  logic P7,   // ENP
  input  logic P8,   // GND
  input  logic P9,   // LOAD_N
  input  logic P10,  // ENT
  output logic P11,  // QD
  output logic P12,  // QC
  output logic P13,  // QB
  output logic P14,  // QA
  output logic P15,  // RCO
  input  logic P16   // VCC
);

  logic [3:0] q_q;
  logic [3:0] q_d;
  logic [3:0] qNext;
  logic       powered;

  assign powered = P16 & ~P8;

  // Ternaries let an unknown LOAD_N propagate as X instead of picking a branch.
  always_comb begin
    qNext = (q_q >= COUNT_MAX) ? 4'd0 : q_q + 4'd1;
    q_d   = !P9 ? {P6, P5, P4, P3} : ((P7 & P10) ? qNext : q_q);
  end

  // No reset value: the count stays unknown until the first clear or load.
  always_ff @(posedge P2) begin
    if (powered) begin
      q_q <= P1 ? 4'd0 : q_d;
    end
  end

  assign P14 = q_q[0];
  assign P13 = q_q[1];
  assign P12 = q_q[2];
  assign P11 = q_q[3];
  assign P15 = P10 & (q_q == COUNT_MAX) & powered;

endmodule

// File: tb/tb_sn74163h.sv
// Directed bench for sn74163h: a vector table for the 4-bit counter plus
// hand-written sequences for ENT/RCO, between-edge pulses, decade and cascade.
module tb_sn74163h;

  typedef struct packed {
    logic       rst;
    logic       loadN;
    logic       enp;
    logic       ent;
    logic       vcc;
    logic       gnd;
    logic [3:0] data;
    logic [3:0] expQ;
    logic       expRco;
  } vec_t;

  vec_t vecs[$];
  int   nApplied = 0;
  int   nFail    = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main hex counter
  logic       rst, loadN, enp, ent, vcc, gnd;
  logic [3:0] data;
  logic       qa, qb, qc, qd, rco;

  sn74163h #(.COUNT_MAX(4'd15)) dut (
    .P1(rst), .P2(clk), .P3(data[0]), .P4(data[1]), .P5(data[2]), .P6(data[3]),
    .P7(enp), .P8(gnd), .P9(loadN), .P10(ent),
    .P11(qd), .P12(qc), .P13(qb), .P14(qa), .P15(rco), .P16(vcc)
  );

  // Decade variant
  logic       dRst, dLoadN, dEnp, dEnt, dVcc;
  logic [3:0] dData;
  logic       dQa, dQb, dQc, dQd, dRco;

  sn74163h #(.COUNT_MAX(4'd9)) dutDec (
    .P1(dRst), .P2(clk), .P3(dData[0]), .P4(dData[1]), .P5(dData[2]), .P6(dData[3]),
    .P7(dEnp), .P8(1'b0), .P9(dLoadN), .P10(dEnt),
    .P11(dQd), .P12(dQc), .P13(dQb), .P14(dQa), .P15(dRco), .P16(dVcc)
  );

  // Two-stage cascade: RCO of stage 0 drives ENT of stage 1
  logic       cRst, cEnp, cVcc;
  logic [3:0] c0Q, c1Q;
  logic       c0Rco, c1Rco;

  sn74163h #(.COUNT_MAX(4'd15)) dutC0 (
    .P1(cRst), .P2(clk), .P3(1'b0), .P4(1'b0), .P5(1'b0), .P6(1'b0),
    .P7(cEnp), .P8(1'b0), .P9(1'b1), .P10(1'b1),
    .P11(c0Q[3]), .P12(c0Q[2]), .P13(c0Q[1]), .P14(c0Q[0]), .P15(c0Rco), .P16(cVcc)
  );

  sn74163h #(.COUNT_MAX(4'd15)) dutC1 (
    .P1(cRst), .P2(clk), .P3(1'b0), .P4(1'b0), .P5(1'b0), .P6(1'b0),
    .P7(cEnp), .P8(1'b0), .P9(1'b1), .P10(c0Rco),
    .P11(c1Q[3]), .P12(c1Q[2]), .P13(c1Q[1]), .P14(c1Q[0]), .P15(c1Rco), .P16(cVcc)
  );

  task automatic addVec(input logic r, input logic ln, input logic ep, input logic et,
                        input logic vc, input logic gn, input logic [3:0] dt,
                        input logic [3:0] eq, input logic erc);
    vec_t v;
    v.rst = r; v.loadN = ln; v.enp = ep; v.ent = et; v.vcc = vc; v.gnd = gn;
    v.data = dt; v.expQ = eq; v.expRco = erc;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    rst = v.rst; loadN = v.loadN; enp = v.enp; ent = v.ent;
    vcc = v.vcc; gnd = v.gnd; data = v.data;
  endtask

  task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
    nApplied++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Advance past the next rising edge and settle before sampling
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b0; loadN = 1'b1; enp = 1'b0; ent = 1'b0; vcc = 1'b1; gnd = 1'b0; data = 4'd0;
    dRst = 1'b0; dLoadN = 1'b1; dEnp = 1'b0; dEnt = 1'b0; dVcc = 1'b0; dData = 4'd0;
    cRst = 1'b0; cEnp = 1'b0; cVcc = 1'b0;

    // Clear, then count 1..15,0,1,2,3
    addVec(1, 1, 1, 1, 1, 0, 4'd0, 4'd0, 0);
    for (int i = 1; i < 20; i++) begin
      addVec(0, 1, 1, 1, 1, 0, 4'd0, 4'(i % 16), (i % 16) == 15);
    end
    // Load beats count, clear beats load
    addVec(0, 0, 1, 1, 1, 0, 4'd5,  4'd5,  0);
    addVec(0, 0, 1, 1, 1, 0, 4'd10, 4'd10, 0);
    addVec(0, 0, 1, 1, 1, 0, 4'd5,  4'd5,  0);
    addVec(1, 0, 1, 1, 1, 0, 4'd10, 4'd0,  0);
    // Enables
    addVec(0, 0, 1, 1, 1, 0, 4'd3, 4'd3, 0);
    for (int i = 0; i < 3; i++) addVec(0, 1, 0, 1, 1, 0, 4'd0, 4'd3, 0);
    for (int i = 0; i < 3; i++) addVec(0, 1, 1, 0, 1, 0, 4'd0, 4'd3, 0);
    addVec(0, 1, 0, 0, 1, 0, 4'd0, 4'd3, 0);
    // Power gating: VCC low, then GND high
    addVec(0, 0, 0, 1, 1, 0, 4'd7, 4'd7, 0);
    for (int i = 0; i < 4; i++) addVec(0, 1, 1, 1, 0, 0, 4'd0, 4'd7, 0);
    addVec(1, 1, 1, 1, 0, 0, 4'd0, 4'd7, 0);
    addVec(0, 1, 1, 1, 1, 0, 4'd0, 4'd8, 0);
    for (int i = 0; i < 3; i++) addVec(0, 1, 1, 1, 1, 1, 4'd0, 4'd8, 0);
    addVec(0, 1, 1, 1, 1, 0, 4'd0, 4'd9, 0);
    // Terminal count, RCO masked when unpowered, wrap
    addVec(0, 0, 1, 1, 1, 0, 4'd14, 4'd14, 0);
    addVec(0, 1, 1, 1, 1, 0, 4'd0,  4'd15, 1);
    addVec(0, 1, 1, 1, 0, 0, 4'd0,  4'd15, 0);
    addVec(0, 1, 1, 1, 1, 0, 4'd0,  4'd0,  0);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i]);
      tick();
      checkOutput($sformatf("vec%0d_q", i), {4'd0, qd, qc, qb, qa}, {4'd0, vecs[i].expQ});
      checkOutput($sformatf("vec%0d_rco", i), {7'd0, rco}, {7'd0, vecs[i].expRco});
    end

    // RCO follows ENT without a clock
    rst = 1'b0; loadN = 1'b0; data = 4'd15; enp = 1'b0; ent = 1'b0; vcc = 1'b1; gnd = 1'b0;
    tick();
    loadN = 1'b1;
    checkOutput("ent_q15", {4'd0, qd, qc, qb, qa}, 8'd15);
    checkOutput("ent_low_rco", {7'd0, rco}, 8'd0);
    ent = 1'b1; #1;
    checkOutput("ent_rise_rco", {7'd0, rco}, 8'd1);
    ent = 1'b0; #1;
    checkOutput("ent_fall_rco", {7'd0, rco}, 8'd0);
    ent = 1'b1; #1;
    checkOutput("ent_rise2_rco", {7'd0, rco}, 8'd1);

    // Pulses on clear, load and ENP between edges leave Q alone
    rst = 1'b1; #1; rst = 1'b0;
    data = 4'd3; loadN = 1'b0; #1; loadN = 1'b1;
    enp = 1'b1; #1; enp = 1'b0;
    checkOutput("pulse_noclk_q", {4'd0, qd, qc, qb, qa}, 8'd15);
    tick();
    checkOutput("pulse_edge_q", {4'd0, qd, qc, qb, qa}, 8'd15);

    // Decade variant: count 1..9,0 then out-of-range load
    dVcc = 1'b1; dRst = 1'b1; dEnp = 1'b1; dEnt = 1'b1;
    tick();
    checkOutput("dec_clear", {4'd0, dQd, dQc, dQb, dQa}, 8'd0);
    dRst = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      checkOutput($sformatf("dec_q%0d", i), {4'd0, dQd, dQc, dQb, dQa}, 8'(i % 10));
      checkOutput($sformatf("dec_rco%0d", i), {7'd0, dRco}, {7'd0, (i % 10) == 9});
    end
    dLoadN = 1'b0; dData = 4'd12;
    tick();
    dLoadN = 1'b1;
    checkOutput("dec_load12", {4'd0, dQd, dQc, dQb, dQa}, 8'd12);
    checkOutput("dec_load12_rco", {7'd0, dRco}, 8'd0);
    tick();
    checkOutput("dec_oor_wrap", {4'd0, dQd, dQc, dQb, dQa}, 8'd0);

    // Cascade: combined value tracks edge count, stage 1 steps on 16 and 32
    cVcc = 1'b1; cRst = 1'b1; cEnp = 1'b1;
    tick();
    checkOutput("cas_clear", {c1Q, c0Q}, 8'd0);
    cRst = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      checkOutput($sformatf("cas_edge%0d", n), {c1Q, c0Q}, 8'(n % 256));
      if (n == 15 || n == 16 || n == 31 || n == 32) begin
        checkOutput($sformatf("cas_stage1_edge%0d", n), {4'd0, c1Q}, 8'(n / 16));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", nApplied, nFail);
    $finish;
  end

endmodule
